// File: rtl/fire8_ofm_pkg.sv
// Shared defaults, derived constants and FSM state type for the fire8 ofm writer.
package fire8_ofm_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DSP_NO = 256;
  localparam int DEF_WOUT   = 8;
  localparam int DEF_PIX_NO = DEF_WOUT * DEF_WOUT;
  localparam int DEF_ADDR_W = $clog2(DEF_DSP_NO * DEF_PIX_NO);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } wr_state_t;

endpackage

// File: rtl/ofm_capture_buf.sv
// DSP_NO x WIDTH capture register bank: parallel load on a strobe, indexed read mux.
module ofm_capture_buf
  import fire8_ofm_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DSP_NO = DEF_DSP_NO,
  parameter int IDX_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] din [0:DSP_NO-1],
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] buf_q [0:DSP_NO-1];

  // NOTE: the bank has no reset; every entry is written before it is read, so a
  // reset would only add a clear path to thousands of flops. Sequential state uses <=.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < DSP_NO; i++) buf_q[i] <= din[i];
    end
  end

  assign rd_data = buf_q[rd_idx];

endmodule

// File: rtl/fire8_ofm_writer.sv
// Serializes each captured ofm vector into the fmap RAM in channel-major order.
// Optional sticky overrun detection is compiled in with OFM_OVERRUN_CHECK_EN.
module fire8_ofm_writer
  import fire8_ofm_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DSP_NO = DEF_DSP_NO,
  parameter int WOUT   = DEF_WOUT,
  parameter int ADDR_W = $clog2(DSP_NO * WOUT * WOUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              layer_sample,
  input  logic [WIDTH-1:0]  ofm [0:DSP_NO-1],
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              ram_feedback,
  output logic              overrun
);

  localparam int PIX_NO = WOUT * WOUT;
  localparam int CH_W   = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int PIX_W  = (PIX_NO > 1) ? $clog2(PIX_NO) : 1;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(DSP_NO - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_NO - 1);

  wr_state_t        state;
  logic [CH_W-1:0]  ch_cnt;
  logic [PIX_W-1:0] pix_cnt;
  logic [WIDTH-1:0] cap_data;
  logic             cap_load;

  // Only an idle writer accepts a new vector; strobes while draining or done are dropped.
  assign cap_load = (state == IDLE) && layer_sample;

  ofm_capture_buf #(
    .WIDTH  (WIDTH),
    .DSP_NO (DSP_NO),
    .IDX_W  (CH_W)
  ) u_capture_buf (
    .clk     (clk),
    .load    (cap_load),
    .din     (ofm),
    .rd_idx  (ch_cnt),
    .rd_data (cap_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ch_cnt       <= '0;
      pix_cnt      <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ram_feedback <= 1'b0;
    end else begin
      ram_we       <= 1'b0;
      busy         <= 1'b0;
      ram_feedback <= 1'b0;
      case (state)
        IDLE: begin
          if (layer_sample) begin
            ch_cnt <= '0;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          ram_we    <= 1'b1;
          busy      <= 1'b1;
          ram_addr  <= ADDR_W'(ch_cnt) * ADDR_W'(PIX_NO) + ADDR_W'(pix_cnt);
          ram_wdata <= cap_data;
          if (ch_cnt == CH_LAST) begin
            ch_cnt <= '0;
            if (pix_cnt == PIX_LAST) begin
              state <= DONE;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
              state   <= IDLE;
            end
          end else begin
            ch_cnt <= ch_cnt + 1'b1;
          end
        end
        DONE: begin
          // done is still low on the first DONE cycle, giving a single feedback pulse.
          ram_feedback <= ~done;
          done         <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OFM_OVERRUN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (layer_sample && (state == DRAIN)) begin
      overrun <= 1'b1;
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fire8_ofm_writer.sv
// Self-checking bench for fire8_ofm_writer against a queue-based write-sequence model.
module tb_fire8_ofm_writer;

  localparam int WIDTH  = 16;
  localparam int DSP_NO = 256;
  localparam int WOUT   = 8;
  localparam int PIX_NO = WOUT * WOUT;
  localparam int ADDR_W = 14;
`ifdef OFM_OVERRUN_CHECK_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wr_t;

  logic              clk;
  logic              rst;
  logic              layer_sample;
  logic [WIDTH-1:0]  ofm [0:DSP_NO-1];
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_wdata;
  logic              busy;
  logic              done;
  logic              ram_feedback;
  logic              overrun;

  fire8_ofm_writer #(
    .WIDTH  (WIDTH),
    .DSP_NO (DSP_NO),
    .WOUT   (WOUT),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .layer_sample (layer_sample),
    .ofm          (ofm),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .busy         (busy),
    .done         (done),
    .ram_feedback (ram_feedback),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Observed RAM traffic and expected traffic from the model.
  wr_t wr_q [$];
  wr_t exp_q [$];
  int  m_pix;
  int  cyc = 0;
  int  first_we_cyc, last_we_cyc, fb_cyc;
  int  busy_cnt, busy_err, fb_cnt;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (wr_q.size() == 0) first_we_cyc = cyc;
      wr_q.push_back({ram_addr, ram_wdata});
      last_we_cyc = cyc;
    end
    if (busy === 1'b1) busy_cnt++;
    if (busy !== ram_we) busy_err++;
    if (ram_feedback === 1'b1) begin
      fb_cnt++;
      fb_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_q.delete();
    exp_q.delete();
    busy_cnt = 0;
    busy_err = 0;
    fb_cnt   = 0;
    fb_cyc   = -1;
    first_we_cyc = -1;
    last_we_cyc  = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    layer_sample = 1'b0;
    tick(2);
    rst = 1'b0;
    m_pix = 0;
    clear_mon();
  endtask

  // Accepted vector: every channel lands at ch*PIX_NO + pixel, in channel order.
  task automatic model_accept();
    for (int i = 0; i < DSP_NO; i++)
      exp_q.push_back({ADDR_W'(i * PIX_NO + m_pix), ofm[i]});
    m_pix++;
  endtask

  task automatic send(input bit accepted);
    layer_sample = 1'b1;
    if (accepted) model_accept();
    tick(1);
    layer_sample = 1'b0;
  endtask

  task automatic rand_ofm();
    for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'($urandom);
  endtask

  task automatic wait_writes(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (wr_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  function automatic int first_mismatch();
    int n;
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (wr_q[i] !== exp_q[i]) return i;
    if (wr_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic string seq_diag(input int idx);
    wr_t g, w;
    g = '0;
    w = '0;
    if (idx < wr_q.size()) g = wr_q[idx];
    if (idx < exp_q.size()) w = exp_q[idx];
    return $sformatf("at %0d got n=%0d addr=%0d data=%h want n=%0d addr=%0d data=%h",
                     idx, wr_q.size(), g.addr, g.data, exp_q.size(), w.addr, w.data);
  endfunction

  task automatic test_reset_and_single();
    int idx;
    do_reset();
    n_tests++;
    if ({ram_we, busy, done, ram_feedback, overrun} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got we/busy/done/fb/ovr=%b want 00000",
               {ram_we, busy, done, ram_feedback, overrun});
    end
    n_tests++;
    if (ram_addr !== '0 || ram_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_bus got addr=%0d data=%h want 0/0", ram_addr, ram_wdata);
    end
    for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'(i + 1);
    send(1'b1);
    tick(300);
    idx = first_mismatch();
    n_tests++;
    if (idx >= 0) begin
      n_fail++;
      $display("FAIL single_seq %s", seq_diag(idx));
    end
    n_tests++;
    if (busy_cnt !== DSP_NO || busy_err !== 0) begin
      n_fail++;
      $display("FAIL single_busy got cycles=%0d skew=%0d want %0d/0", busy_cnt, busy_err, DSP_NO);
    end
    n_tests++;
    if (last_we_cyc - first_we_cyc !== DSP_NO - 1) begin
      n_fail++;
      $display("FAIL single_contig got span=%0d want %0d", last_we_cyc - first_we_cyc, DSP_NO - 1);
    end
    n_tests++;
    if (ram_we !== 1'b0 || done !== 1'b0 || fb_cnt !== 0) begin
      n_fail++;
      $display("FAIL single_after got we=%b done=%b fb=%0d want 0/0/0", ram_we, done, fb_cnt);
    end
  endtask

  task automatic test_full_layer();
    int  idx;
    wr_t last;
    do_reset();
    for (int p = 0; p < PIX_NO; p++) begin
      for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'(p * 256 + i);
      send(1'b1);
      tick(1008);
    end
    tick(50);
    idx = first_mismatch();
    n_tests++;
    if (idx >= 0) begin
      n_fail++;
      $display("FAIL layer_seq %s", seq_diag(idx));
    end
    last = (wr_q.size() > 0) ? wr_q[wr_q.size() - 1] : '0;
    n_tests++;
    if (wr_q.size() !== DSP_NO * PIX_NO || last.addr !== 14'd16383 || last.data !== 16'h3FFF) begin
      n_fail++;
      $display("FAIL layer_last got n=%0d addr=%0d data=%h want %0d/16383/3fff",
               wr_q.size(), last.addr, last.data, DSP_NO * PIX_NO);
    end
    n_tests++;
    if (fb_cnt !== 1 || fb_cyc !== last_we_cyc + 1) begin
      n_fail++;
      $display("FAIL layer_feedback got pulses=%0d at=%0d want 1 at %0d", fb_cnt, fb_cyc, last_we_cyc + 1);
    end
    n_tests++;
    if (done !== 1'b1 || ram_feedback !== 1'b0) begin
      n_fail++;
      $display("FAIL layer_done got done=%b fb=%b want 1/0", done, ram_feedback);
    end
  endtask

  task automatic test_after_done();
    clear_mon();
    for (int k = 0; k < 3; k++) begin
      rand_ofm();
      send(1'b0);
      tick(20);
    end
    tick(300);
    n_tests++;
    if (wr_q.size() !== 0 || busy_cnt !== 0 || fb_cnt !== 0) begin
      n_fail++;
      $display("FAIL post_done got writes=%0d busy=%0d fb=%0d want 0/0/0", wr_q.size(), busy_cnt, fb_cnt);
    end
    n_tests++;
    if (done !== 1'b1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL post_done_flags got done=%b ovr=%b want 1/0", done, overrun);
    end
  endtask

  task automatic test_strobe_in_drain();
    bit ok;
    int idx;
    do_reset();
    rand_ofm();
    send(1'b1);
    wait_writes(100, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_wait got %0d writes want 100 (timeout)", wr_q.size());
    end
    rand_ofm();
    send(1'b0);
    tick(300);
    idx = first_mismatch();
    n_tests++;
    if (idx >= 0) begin
      n_fail++;
      $display("FAIL drain_seq %s", seq_diag(idx));
    end
    n_tests++;
    if (overrun !== OVR_EN) begin
      n_fail++;
      $display("FAIL drain_overrun got %b want %b", overrun, OVR_EN);
    end
    rand_ofm();
    send(1'b1);
    tick(300);
    idx = first_mismatch();
    n_tests++;
    if (idx >= 0 || overrun !== OVR_EN) begin
      n_fail++;
      $display("FAIL drain_sticky ovr=%b want %b %s", overrun, OVR_EN, seq_diag(idx));
    end
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    int idx;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      rand_ofm();
      send(1'b1);
      tick(300);
    end
    rand_ofm();
    send(1'b1);
    wait_writes(3 * DSP_NO + 50, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rst_wait got %0d writes want %0d (timeout)", wr_q.size(), 3 * DSP_NO + 50);
    end
    rst = 1'b1;
    tick(1);
    n_tests++;
    if ({ram_we, busy, done, ram_feedback, overrun} !== 5'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
      n_fail++;
      $display("FAIL rst_outputs got we/busy/done/fb/ovr=%b addr=%0d data=%h want all 0",
               {ram_we, busy, done, ram_feedback, overrun}, ram_addr, ram_wdata);
    end
    exp_q = exp_q[0:3 * DSP_NO + 49];
    tick(20);
    idx = first_mismatch();
    n_tests++;
    if (idx >= 0) begin
      n_fail++;
      $display("FAIL rst_abort %s", seq_diag(idx));
    end
    rst = 1'b0;
    m_pix = 0;
    clear_mon();
    tick(2);
    rand_ofm();
    send(1'b1);
    tick(300);
    idx = first_mismatch();
    n_tests++;
    if (idx >= 0 || wr_q.size() == 0 || wr_q[0].addr !== '0) begin
      n_fail++;
      $display("FAIL rst_restart %s", seq_diag((idx < 0) ? 0 : idx));
    end
  endtask

  task automatic test_strobe_on_last_write();
    bit ok;
    int idx;
    do_reset();
    rand_ofm();
    send(1'b1);
    wait_writes(DSP_NO - 1, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL last_wait got %0d writes want %0d (timeout)", wr_q.size(), DSP_NO - 1);
    end
    rand_ofm();
    send(1'b0);
    tick(300);
    idx = first_mismatch();
    n_tests++;
    if (idx >= 0) begin
      n_fail++;
      $display("FAIL last_dropped %s", seq_diag(idx));
    end
    n_tests++;
    if (overrun !== OVR_EN) begin
      n_fail++;
      $display("FAIL last_overrun got %b want %b", overrun, OVR_EN);
    end
    rand_ofm();
    send(1'b1);
    tick(300);
    idx = first_mismatch();
    n_tests++;
    if (idx >= 0) begin
      n_fail++;
      $display("FAIL last_next_pix %s", seq_diag(idx));
    end
  endtask

  initial begin
    rst = 1'b1;
    layer_sample = 1'b0;
    for (int i = 0; i < DSP_NO; i++) ofm[i] = '0;
    tick(2);
    test_reset_and_single();
    test_full_layer();
    test_after_done();
    test_strobe_in_drain();
    test_reset_mid_drain();
    test_strobe_on_last_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fire8_ofm_writer.md
Name: fire8_ofm_writer

Overview:
Consumer end of the layer-output interface. Captures the parallel DSP_NO-wide ofm vector on each layer sample strobe and serializes it into the output feature-map RAM, one word per cycle, in channel-major order. After WOUT*WOUT pixel vectors have been written, it raises ram_feedback back to the producing layer. It sits between the fire8 expand3 compute layer and the fmap RAM read by the next layer.

Parameters:
WIDTH, 16, bits per ofm word
DSP_NO, 256, output channels per sample (vector length)
WOUT, 8, output spatial dimension; WOUT*WOUT pixel vectors per layer
ADDR_W, $clog2(DSP_NO*WOUT*WOUT), RAM address width (14 at defaults)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous active-high reset
layer_sample  in  1  one-cycle strobe; ofm is valid in the same cycle
ofm  in  WIDTH x [0:DSP_NO-1]  unpacked array from the layer, held stable while layer_sample is high
ram_we  out  1  RAM write enable (registered)
ram_addr  out  ADDR_W  RAM write address (registered)
ram_wdata  out  WIDTH  RAM write data (registered)
busy  out  1  high while a vector is being drained
done  out  1  high from layer completion until reset
ram_feedback  out  1  one-cycle pulse on layer completion; the producer latches it
overrun  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset: state IDLE; ch_cnt=0, pix_cnt=0; ram_we=0, ram_addr=0, ram_wdata=0, busy=0, done=0, ram_feedback=0, overrun=0. Capture buffer contents are not cleared. A reset mid-drain aborts the drain; no further writes occur.
- FSM states:
  - IDLE: on layer_sample, copy ofm[0..DSP_NO-1] into cap_buf, set ch_cnt=0, go to DRAIN.
  - DRAIN: each cycle register ram_we=1, ram_addr=ch_cnt*WOUT*WOUT+pix_cnt, ram_wdata=cap_buf[ch_cnt], then increment ch_cnt.
    - At ch_cnt==DSP_NO-1: clear ch_cnt. If pix_cnt==WOUT*WOUT-1, go to DONE. Otherwise increment pix_cnt and go to IDLE.
  - DONE: ram_feedback=1 for the first cycle only, done=1 held. All further layer_sample strobes are ignored. The producer emits extra strobes past the last pixel, so this is required.
- Timing and widths:
  - The sample strobe arrives at edge E0 and capture happens at E0.
  - Writes are visible in the cycles following edges E1..E_DSP_NO, i.e. exactly DSP_NO consecutive ram_we cycles. busy is high over the same cycles.
  - ram_we=0 in all other cycles.
  - Address arithmetic uses ADDR_W bits; the maximum address is DSP_NO*WOUT*WOUT-1, so there is no wrap.
- Simultaneous events:
  - layer_sample in the same cycle as the last DRAIN write: ignored, and counts as an overrun.
  - layer_sample during DRAIN: ignored; the buffer is not overwritten.
  - In both cases overrun is set if the feature is enabled.
- The producer's sample period (KERNEL_DIM^2*CHIN+1 cycles) exceeds DSP_NO, so overrun is an error condition only.

Optional Feature:
OFM_OVERRUN_CHECK_EN
- Defined: overrun is set to 1 in the cycle after any layer_sample that arrives while state != IDLE and state != DONE. It stays sticky until rst.
- Undefined: overrun is tied to 0 and the detection logic is absent. Dropping the strobe is unchanged.

Decomposition:
- Package fire8_ofm_pkg:
  - WIDTH, DSP_NO and WOUT defaults
  - derived constants PIX_NO=WOUT*WOUT and ADDR_W
  - state enum {IDLE, DRAIN, DONE} typedef as wr_state_t
- One sub-module, ofm_capture_buf: DSP_NO x WIDTH register bank with a load strobe and a ch_cnt-indexed read mux. The top level holds the FSM, counters and output registers.

Test Plan:
1. Reset, then one strobe with ofm[i]=i+1 -> 256 consecutive ram_we cycles. addr=i*64, wdata=i+1 for i=0..255, busy high for exactly 256 cycles, then ram_we=0.
2. 64 strobes spaced 1009 cycles apart, with ofm[i]=pix*256+i -> 16384 writes. The last write has addr 16383 and wdata 0x3FFF. ram_feedback pulses exactly once, one cycle after the last write; done stays 1.
3. After done, 3 more strobes -> no ram_we, no second ram_feedback, and overrun stays 0.
4. Strobe during DRAIN at write 100 (feature on) -> the write sequence is unchanged (cap_buf not overwritten), overrun=1 sticky. With the feature off, overrun=0.
5. rst asserted at write 50 of pixel 3 -> ram_we=0 next cycle and all outputs at reset values. A new strobe restarts at pix 0 (addr 0).
6. Strobe coincident with the final DRAIN cycle -> strobe dropped, pix_cnt advances by 1 only, overrun=1 (feature on).
